// File: rtl/noc_out_port.sv
// Router output port: drains one output FIFO and forwards flits to one of five
// neighbours over a 4-phase req/ack handshake, XY-routed wormhole style.
module noc_out_port #(
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0,
  parameter int ADDR_W  = 1,
  parameter int DX_LSB  = 8,
  parameter int DY_LSB  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] q,
  input  logic        empty,
  input  logic [6:0]  usedw,
  output logic        rdreq,
  output logic [31:0] dataOut,
  output logic [4:0]  Outr,
  input  logic [4:0]  Outw,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    REQ   = 3'd3,
    REL   = 3'd4
  } state_t;

  localparam logic [2:0] DIR_W = 3'd0;
  localparam logic [2:0] DIR_S = 3'd1;
  localparam logic [2:0] DIR_E = 3'd2;
  localparam logic [2:0] DIR_N = 3'd3;
  localparam logic [2:0] DIR_L = 3'd4;

  localparam logic [ADDR_W-1:0] X_HERE = ADDR_W'(X_COORD);
  localparam logic [ADDR_W-1:0] Y_HERE = ADDR_W'(Y_COORD);

  function automatic logic [2:0] xy_route(input logic [31:0] hdr);
    logic [ADDR_W-1:0] dx;
    logic [ADDR_W-1:0] dy;
    dx = hdr[DX_LSB +: ADDR_W];
    dy = hdr[DY_LSB +: ADDR_W];
    if (dx > X_HERE)      return DIR_E;
    else if (dx < X_HERE) return DIR_W;
    else if (dy > Y_HERE) return DIR_N;
    else if (dy < Y_HERE) return DIR_S;
    else                  return DIR_L;
  endfunction

  function automatic logic [4:0] onehot(input logic [2:0] dir);
    case (dir)
      DIR_W:   return 5'b00001;
      DIR_S:   return 5'b00010;
      DIR_E:   return 5'b00100;
      DIR_N:   return 5'b01000;
      DIR_L:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic        rdreq_r, rdreq_s;
  logic [31:0] data_r, data_s;
  logic [4:0]  outr_r, outr_s;
  logic [2:0]  route_r, route_s;
  logic        pkt_active_r, pkt_active_s;
  logic [2:0]  hdr_route_s;
  logic        ack_s;
  logic        unused_s;

  assign unused_s    = ^usedw;
  assign hdr_route_s = xy_route(q);
  // Only the ack line of the latched route counts; other neighbours are ignored.
  assign ack_s       = |(onehot(route_r) & Outw);

  // State and all output registers; reset drops any flit or packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      rdreq_r      <= 1'b0;
      data_r       <= 32'd0;
      outr_r       <= 5'd0;
      route_r      <= 3'd0;
      pkt_active_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      rdreq_r      <= rdreq_s;
      data_r       <= data_s;
      outr_r       <= outr_s;
      route_r      <= route_s;
      pkt_active_r <= pkt_active_s;
    end
  end

  // Next-state and next-output logic for the read / latch / handshake sequence.
  always_comb begin
    state_s      = state_r;
    rdreq_s      = 1'b0;
    data_s       = data_r;
    outr_s       = outr_r;
    route_s      = route_r;
    pkt_active_s = pkt_active_r;
    case (state_r)
      IDLE: begin
        if (!empty) begin
          rdreq_s = 1'b1;
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        state_s = LATCH;
      end
      LATCH: begin
        data_s = q;
        if (!pkt_active_r) begin
          route_s      = hdr_route_s;
          pkt_active_s = 1'b1;
          outr_s       = onehot(hdr_route_s);
        end else begin
          outr_s = onehot(route_r);
        end
        state_s = REQ;
      end
      REQ: begin
        if (ack_s) begin
          outr_s  = 5'd0;
          state_s = REL;
        end else begin
          state_s = REQ;
        end
      end
      REL: begin
        if (!ack_s) begin
          // Tail released: the packet ends and the route is forgotten.
          if (data_r[4]) begin
            pkt_active_s = 1'b0;
            route_s      = 3'd0;
          end else begin
            pkt_active_s = pkt_active_r;
          end
          state_s = IDLE;
        end else begin
          state_s = REL;
        end
      end
      default: begin
        state_s = IDLE;
        outr_s  = 5'd0;
      end
    endcase
  end

  assign rdreq   = rdreq_r;
  assign dataOut = data_r;
  assign Outr    = outr_r;
  assign busy    = pkt_active_r;

endmodule

// File: tb/tb_noc_out_port.sv
// Randomized bench for noc_out_port: FIFO and neighbour models around the DUT,
// expected transfers derived from XY routing of each packet's header.
module tb_noc_out_port;

  localparam int TX = 0;
  localparam int TY = 0;
  localparam logic [4:0] D_W = 5'b00001;
  localparam logic [4:0] D_S = 5'b00010;
  localparam logic [4:0] D_E = 5'b00100;
  localparam logic [4:0] D_N = 5'b01000;
  localparam logic [4:0] D_L = 5'b10000;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] q     = 32'd0;
  logic        empty = 1'b1;
  logic [6:0]  usedw = 7'd0;
  logic        rdreq;
  logic [31:0] dataOut;
  logic [4:0]  Outr;
  logic [4:0]  Outw;
  logic        busy;

  noc_out_port dut (
    .clk(clk), .reset(reset), .q(q), .empty(empty), .usedw(usedw),
    .rdreq(rdreq), .dataOut(dataOut), .Outr(Outr), .Outw(Outw), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  dir;
    logic [31:0] flit;
  } xfer_t;

  logic [31:0] fifo_q[$];
  xfer_t       exp_q[$];

  // XY routing for a router at (TX,TY) with 1-bit coordinates at bits 8 and 12.
  function automatic logic [4:0] route_of(input logic [31:0] h);
    int dx;
    int dy;
    dx = int'(h[8]);
    dy = int'(h[12]);
    if (dx > TX) return D_E;
    if (dx < TX) return D_W;
    if (dy > TY) return D_N;
    if (dy < TY) return D_S;
    return D_L;
  endfunction

  task automatic push_flit(input logic [31:0] f, input logic [4:0] dir);
    fifo_q.push_back(f);
    exp_q.push_back(xfer_t'({dir, f}));
  endtask

  task automatic push_pkt(input int n);
    logic [31:0] f;
    logic [4:0]  dir;
    dir = D_L;
    for (int i = 0; i < n; i++) begin
      f    = $urandom;
      f[4] = (i == n - 1);
      if (i == 0) dir = route_of(f);
      push_flit(f, dir);
    end
  endtask

  // FIFO model: a read sampled at an edge presents the next word one cycle later.
  logic rd_seen;
  logic emp_seen;
  always @(posedge clk) begin
    rd_seen  = rdreq;
    emp_seen = empty;
    #1;
    if (rd_seen) begin
      chk("rdreq_while_empty", 32'(emp_seen), 32'd0);
      if (fifo_q.size() != 0) q = fifo_q.pop_front();
    end
    empty = (fifo_q.size() == 0);
    usedw = 7'(fifo_q.size());
  end

  // Outr must never carry more than one request.
  always @(negedge clk) begin
    if (reset) chk("outr_onehot0", 32'($onehot0(Outr)), 32'd1);
  end

  int         ack_dly  = 1;
  int         ack_hold = 0;
  bit         nbr_en   = 1'b1;
  logic [4:0] stray    = 5'd0;
  logic [4:0] ack_bits = 5'd0;
  assign Outw = stray | ack_bits;

  // Neighbour model: checks each offered flit against the scoreboard, then acks.
  always begin : nbr
    xfer_t      e;
    logic [4:0] dir;
    bit         rd_hit;
    @(negedge clk);
    if (nbr_en && Outr != 5'd0) begin
      dir = Outr;
      chk("busy_during_xfer", 32'(busy), 32'd1);
      if (exp_q.size() == 0) begin
        chk("xfer_unexpected", 32'(Outr), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_dir", 32'(Outr), 32'(e.dir));
        chk("xfer_data", dataOut, e.flit);
      end
      repeat (ack_dly) begin
        @(negedge clk);
        chk("req_stable", 32'(Outr), 32'(dir));
      end
      ack_bits = dir;
      @(negedge clk);
      chk("req_drop_after_ack", 32'(Outr), 32'd0);
      rd_hit = 1'b0;
      repeat (ack_hold) begin
        @(negedge clk);
        if (rdreq) rd_hit = 1'b1;
      end
      chk("no_read_while_ack_high", 32'(rd_hit), 32'd0);
      ack_bits = 5'd0;
    end
  end

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (ack_dly + ack_hold + 6) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("reset_rdreq", 32'(rdreq), 32'd0);
    chk("reset_outr", 32'(Outr), 32'd0);
    chk("reset_data", dataOut, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single-flit packet heading east, fixed latency from the read strobe
    ack_dly  = 1;
    ack_hold = 0;
    push_flit(32'h0000_1110, D_E);
    t = 0;
    while (!rdreq && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t1_rdreq_seen", 32'(rdreq), 32'd1);
    @(negedge clk);
    chk("t1_rdreq_pulse", 32'(rdreq), 32'd0);
    @(negedge clk);
    chk("t1_outr_east", 32'(Outr), 32'(D_E));
    chk("t1_data", dataOut, 32'h0000_1110);
    wait_drain(100);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // 2: three-flit packet north; body and tail follow the header's route
    push_flit(32'h0000_1000, D_N);
    push_flit(32'h0000_0000, D_N);
    push_flit(32'h0000_0010, D_N);
    wait_drain(200);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // 3: local delivery with a stray ack on the west line
    stray   = D_W;
    ack_dly = 3;
    push_flit(32'h0000_0010, D_L);
    wait_drain(100);
    chk("t3_busy_end", 32'(busy), 32'd0);
    stray   = 5'd0;
    ack_dly = 1;

    // 4: FIFO underrun between header and tail
    push_flit(32'h0000_1100, D_E);
    wait_drain(100);
    for (int i = 0; i < 10; i++) begin
      chk("t4_gap_rdreq", 32'(rdreq), 32'd0);
      chk("t4_gap_outr", 32'(Outr), 32'd0);
      chk("t4_gap_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    push_flit(32'h0000_0010, D_E);
    wait_drain(100);
    chk("t4_busy_end", 32'(busy), 32'd0);

    // 5: long-held ack delays the next read
    ack_hold = 6;
    push_flit(32'h0000_1000, D_N);
    push_flit(32'h0000_1010, D_N);
    wait_drain(200);
    chk("t5_busy_end", 32'(busy), 32'd0);
    ack_hold = 0;

    // random traffic with random ack timing
    for (int p = 0; p < 40; p++) begin
      ack_dly  = $urandom_range(0, 3);
      ack_hold = $urandom_range(0, 3);
      push_pkt($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) push_pkt($urandom_range(1, 3));
      wait_drain(600);
      chk("rand_busy_end", 32'(busy), 32'd0);
    end
    ack_dly  = 1;
    ack_hold = 0;

    // 6: reset while a header request is pending, then a fresh header
    nbr_en = 1'b0;
    fifo_q.push_back(32'h0000_1100);
    fifo_q.push_back(32'h0000_0010);
    t = 0;
    while (Outr == 5'd0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t6_req_seen", 32'(Outr), 32'(D_E));
    reset = 1'b0;
    #1;
    chk("t6_rst_outr", 32'(Outr), 32'd0);
    chk("t6_rst_rdreq", 32'(rdreq), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_data", dataOut, 32'd0);
    fifo_q.delete();
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    nbr_en = 1'b1;
    push_flit(32'h0000_0010, D_L);
    wait_drain(100);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
